// File: rtl/mmu_rsp_fifo_pkg.sv
// Shared widths for the MMU response path and the response word packing.
// Latency: none (constants only).
// Backpressure: n/a.
package mmu_rsp_fifo_pkg;

    localparam int FIFO_PTR_WIDTH     = 4;
    localparam int REQ_ID_WIDTH       = 8;
    localparam int ALL_PAGE_IDX_WIDTH = 10;
    localparam int FAIL_REASON_WIDTH  = 2;

    // Response words pack {fail_reason, fail, [page_idx], id}, MSB to LSB.
    // The free channel carries no page index.
    localparam int RSP_ALLOC_WIDTH = REQ_ID_WIDTH + ALL_PAGE_IDX_WIDTH + FAIL_REASON_WIDTH + 1;
    localparam int RSP_FREE_WIDTH  = REQ_ID_WIDTH + FAIL_REASON_WIDTH + 1;

endpackage : mmu_rsp_fifo_pkg

// File: rtl/mmu_rsp_fifo_mem.sv
// DEPTH x DATA_WIDTH register array, one write port, one asynchronous read port.
// Latency: write lands at the clock edge, read is combinational from the array.
// Backpressure: none; the caller decides when to write.
//
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. No reset:
// contents are only meaningful where the controlling FIFO says so.
module mmu_rsp_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : mmu_rsp_fifo_mem

// File: rtl/mmu_rsp_fifo.sv
// MMU response FIFO: absorbs arbiter write pulses, presents FWFT valid/ready to host.
// Latency: write-to-valid 1 cycle; flags and data_count follow registered count.
// Backpressure: almost_full at DEPTH-AF_MARGIN entries; writes while full (no pop) are dropped and flag sticky overflow.
//
// Ports: clk, rst (sync, active high); write_en/write_data push side;
// almost_full/full/data_count/overflow status; rsp_valid/rsp_data/rsp_ready host side.
module mmu_rsp_fifo
    import mmu_rsp_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = RSP_ALLOC_WIDTH,
    parameter int DEPTH      = 16,
    parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
    parameter int AF_MARGIN  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  almost_full,
    output logic                  full,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_ready,
    output logic [PTR_WIDTH:0]    data_count,
    output logic                  overflow
);

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] AF_THRESH = (PTR_WIDTH + 1)'(DEPTH - AF_MARGIN);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH:0]   count;
    logic                 overflow_q;
    logic                 push;
    logic                 pop;

    // Full/empty come from count alone; the pointers are equal both when
    // empty and when full, so they cannot tell the two apart.
    assign rsp_valid   = (count != '0);
    assign full        = (count == DEPTH_CNT);
    assign almost_full = (count >= AF_THRESH);
    assign data_count  = count;
    assign overflow    = overflow_q;

    assign pop  = rsp_valid && rsp_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = write_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (write_en && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Writes during reset are suppressed so a dropped word cannot appear later
    // in a slot that the reset just declared empty.
    mmu_rsp_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (write_data),
        .raddr (rd_ptr),
        .rdata (rsp_data)
    );

endmodule : mmu_rsp_fifo

// File: doc/mmu_rsp_fifo.md
# mmu_rsp_fifo

Response FIFO sitting directly downstream of the MMU tree, one instance per response channel (alloc and free). It absorbs single-cycle `write_en` pulses from the response arbiters and presents responses to the host through a first-word-fall-through valid/ready port. It generates the `almost_full` back-pressure the dispatcher uses to stop issuing requests while responses are still in flight.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `REQ_ID_WIDTH+`ALL_PAGE_IDX_WIDTH+`FAIL_REASON_WIDTH+1 ``: response word width. The free channel instantiates with `` `REQ_ID_WIDTH+`FAIL_REASON_WIDTH+1 ``.
- `DEPTH`, default 16: entry count. Must be a power of two, ≥4.
- `PTR_WIDTH`, default `` `FIFO_PTR_WIDTH ``: log2(DEPTH).
- `AF_MARGIN`, default 3: free slots at or below which `almost_full` asserts. Covers MMU pipeline responses already in flight. Range 1..DEPTH-1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `write_en` in 1: push `write_data` this cycle.
- `write_data` in DATA_WIDTH: response word, same field packing as the arbiter output (fail_reason, fail, [page_idx], id; MSB→LSB).
- `almost_full` out 1: `data_count >= DEPTH-AF_MARGIN`.
- `full` out 1: `data_count == DEPTH`.
- `rsp_valid` out 1: head entry present.
- `rsp_data` out DATA_WIDTH: head entry; stable while `rsp_valid && !rsp_ready`.
- `rsp_ready` in 1: host consumes head when `rsp_valid`.
- `data_count` out PTR_WIDTH+1: entries held, 0..DEPTH.
- `overflow` out 1: sticky; a write was dropped.

## Operation
- Storage: DEPTH-entry register array.
- `wr_ptr` and `rd_ptr`, PTR_WIDTH bits each, wrap naturally modulo DEPTH.
- `count` register, PTR_WIDTH+1 bits. Full/empty are derived from `count`, never from pointer equality.
- Push condition: `push = write_en && (!full || pop)`, where `pop = rsp_valid && rsp_ready`.
- On push: `mem[wr_ptr] <= write_data` and `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- Count update: `count` +1 on push-only, −1 on pop-only, unchanged on both or neither.
- Write while full without a simultaneous pop: the word is dropped, `overflow` sets and stays set until `rst`. Pointers and count are unchanged. This is a protocol violation by the producer; `almost_full` exists to prevent it.
- Read side: `rsp_valid = (count != 0)`. `rsp_data = mem[rd_ptr]` (registered storage, combinational head select).
- Read when empty: `rsp_ready` is ignored, nothing changes.
- No bypass: a write into an empty FIFO is visible to the host the following cycle.
- Simultaneous push and pop at count==1: the head is consumed, the new word becomes head next cycle, `count` stays 1.
- Reset: `wr_ptr=0`, `rd_ptr=0`, `count=0`, `overflow=0`. Array contents are not reset.

## Timing
- Outputs after reset: `rsp_valid=0`, `full=0`, `almost_full=0`, `data_count=0`, `overflow=0`. `rsp_data` is don't-care.
- Write-to-valid latency: 1 cycle (word written at edge N is head and valid after edge N if FIFO was empty).
- Pop takes effect at the clock edge where `rsp_valid && rsp_ready`. The next entry is presented in the following cycle with no bubble.
- `almost_full`, `full`, and `data_count` are all derived from registered `count`. They update one cycle after the push or pop that changes them.
- The dispatcher samples `almost_full` only. With AF_MARGIN ≥ MMU pipeline depth, no write arrives while `full`.
- Reset asserted mid-operation discards all queued entries in one cycle. Any `write_en` during a reset cycle is ignored.
- Sustained throughput: one push and one pop per cycle.

## Structure
- `FIFO_PTR_WIDTH`, `REQ_ID_WIDTH`, `ALL_PAGE_IDX_WIDTH`, and `FAIL_REASON_WIDTH` stay in the shared MMU define file; no new constants go there.
- The response field packing order is documented in the shared define file as a comment-free macro pair (`RSP_ALLOC_WIDTH`, `RSP_FREE_WIDTH`). `mmu_tree` and this block both use it.
- One sub-module: `mmu_rsp_fifo_mem`, a DEPTH×DATA_WIDTH register array with one write port and one asynchronous read port. It has no reset.
- Control (pointers, count, flags) stays in `mmu_rsp_fifo`.

## Test plan
- Reset then idle, DEPTH=8, AF_MARGIN=3 -> `rsp_valid=0`, `data_count=0`, `almost_full=0`, `full=0`, `overflow=0`.
- Five single writes 0x11..0x15, `rsp_ready=0` -> `data_count` reaches 5 and `almost_full` asserts the cycle after the 5th write. Then assert `rsp_ready` -> 0x11..0x15 drain in order, one per cycle, with `rsp_valid` dropping after 0x15.
- Fill 8 entries, then `write_en` with 0xAA and `rsp_ready=0` -> 0xAA dropped, `overflow=1`, `data_count=8`. Next drain returns the original 8 words.
- Full, `write_en`=0xBB and pop in the same cycle -> `data_count` stays 8, no overflow, 0xBB is read last.
- Push and pop every cycle for 40 cycles with incrementing data -> output equals input delayed 1 cycle, `data_count` constant, pointers wrap without loss.
- Reset asserted with 6 entries queued and `write_en` high -> next cycle `data_count=0`, `rsp_valid=0`, and the written word is absent.
